muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute/writeback path, directly upstream of the register file write port. It accepts one M-extension operation (operands already read from the register file), computes it over multiple cycles, and delivers the result as a one-cycle write request to the register file. While busy it stalls further issue via `ready_o`.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   // funct3 encoding of the M-extension operations
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
   localparam int          CALC_CYCLES = 32;

   // Two's-complement magnitude of a value whose sign is to be removed
   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operation in flight, result
// delivered as a single-cycle register-file write request.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [4:0]      rd_addr_i,
   output logic [4:0]      rd_addr_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            rd_wren_o,
   output logic            busy_o
);

   muldiv_state_e r_state;
   muldiv_op_e    r_op;
   logic          r_is_div;
   logic          r_neg;       // product / quotient must be negated in FIX
   logic          r_neg_rem;   // remainder must be negated in FIX
   logic [4:0]    r_rd_q;
   logic [5:0]    r_cnt;
   logic [63:0]   r_acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [31:0]   r_opb;       // multiplicand or divisor magnitude
   logic          r_rd_wren;
   logic [4:0]    r_rd_addr;
   logic [31:0]   r_rd_data;

   muldiv_op_e    w_op;
   logic          w_sign_a, w_sign_b, w_neg_a, w_neg_b;
   logic [31:0]   w_mag_a, w_mag_b;
   logic          w_div0, w_ovf, w_fast;
   logic [31:0]   w_fast_res;
   logic [32:0]   w_lhs, w_rhs, w_alu;
   logic [63:0]   w_acc_next;
   logic [63:0]   w_prod;
   logic [31:0]   w_quot, w_rem, w_fix_res;

   // ---------------- capture-side decode ----------------
   assign w_op     = muldiv_op_e'(op_i);
   assign w_sign_a = (w_op == MULH) || (w_op == MULHSU) || (w_op == DIV) || (w_op == REM);
   assign w_sign_b = (w_op == MULH) || (w_op == DIV) || (w_op == REM);
   assign w_neg_a  = w_sign_a && rs1_data_i[31];
   assign w_neg_b  = w_sign_b && rs2_data_i[31];
   assign w_mag_a  = cond_neg32(rs1_data_i, w_neg_a);
   assign w_mag_b  = cond_neg32(rs2_data_i, w_neg_b);

   assign w_div0 = op_i[2] && (rs2_data_i == 32'd0);
   assign w_ovf  = ((w_op == DIV) || (w_op == REM)) &&
                   (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
   assign w_fast = w_div0 || w_ovf;

   // Fast-path result: op_i[1] distinguishes REM* from DIV* within the divide group
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_fast_res = '0;
      if (w_div0)
         w_fast_res = op_i[1] ? rs1_data_i : DIV0_QUOT;
      else if (w_ovf)
         w_fast_res = op_i[1] ? 32'd0 : 32'h8000_0000;
   end

   // ---------------- shared 33-bit adder/subtractor ----------------
   // Multiply adds the multiplicand into the upper half when the multiplier LSB is set;
   // restoring division trial-subtracts the divisor from the shifted remainder.
   assign w_lhs = r_is_div ? r_acc[63:31] : {1'b0, r_acc[63:32]};
   assign w_rhs = (r_is_div || r_acc[0]) ? {1'b0, r_opb} : 33'd0;
   assign w_alu = r_is_div ? (w_lhs - w_rhs) : (w_lhs + w_rhs);

   // One radix-2 step of the selected algorithm
   always_comb begin
      w_acc_next = r_acc;
      if (!r_is_div)
         w_acc_next = {w_alu, r_acc[31:1]};
      else if (w_alu[32])
         w_acc_next = {r_acc[62:0], 1'b0};
      else
         w_acc_next = {w_alu[31:0], r_acc[30:0], 1'b1};
   end

   // ---------------- sign correction and result select ----------------
   assign w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;
   assign w_quot = cond_neg32(r_acc[31:0], r_neg);
   assign w_rem  = cond_neg32(r_acc[63:32], r_neg_rem);

   // Pick the architectural result word for the captured operation
   always_comb begin
      w_fix_res = '0;
      case (r_op)
         MUL:               w_fix_res = w_prod[31:0];
         MULH, MULHSU,
         MULHU:             w_fix_res = w_prod[63:32];
         DIV, DIVU:         w_fix_res = w_quot;
         default:           w_fix_res = w_rem;
      endcase
   end

   // Datapath registers: loaded on transfer, stepped in CALC
   // NOTE: datapath registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk_i) begin
      if (r_state == IDLE && valid_i) begin
         r_op      <= w_op;
         r_is_div  <= op_i[2];
         r_rd_q    <= rd_addr_i;
         r_neg     <= w_neg_a ^ w_neg_b;
         r_neg_rem <= w_neg_a;
         r_opb     <= op_i[2] ? w_mag_b : w_mag_a;
         r_acc     <= op_i[2] ? {32'd0, w_mag_a} : {32'd0, w_mag_b};
      end else if (r_state == CALC) begin
         r_acc <= w_acc_next;
      end
   end

   // Control FSM with registered write-request outputs
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_rd_wren <= 1'b0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (valid_i) begin
                  r_cnt <= '0;
                  if (w_fast) begin
                     r_rd_data <= w_fast_res;
                     r_rd_addr <= rd_addr_i;
                     r_rd_wren <= (rd_addr_i != 5'd0);
                     r_state   <= DONE;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               if (r_cnt == 6'(CALC_CYCLES - 1))
                  r_state <= FIX;
               else
                  r_cnt <= r_cnt + 6'd1;
            end
            FIX: begin
               r_rd_data <= w_fix_res;
               r_rd_addr <= r_rd_q;
               r_rd_wren <= (r_rd_q != 5'd0);
               r_state   <= DONE;
            end
            default: begin
               r_rd_wren <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign ready_o   = (r_state == IDLE);
   assign busy_o    = ~ready_o;
   assign rd_wren_o = r_rd_wren;
   assign rd_addr_o = r_rd_addr;
   assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] rs1_data_i = '0;
   logic [31:0] rs2_data_i = '0;
   logic [4:0]  rd_addr_i = '0;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;
   logic        rd_wren_o;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .op_i       (op_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .rd_addr_i  (rd_addr_i),
      .rd_addr_o  (rd_addr_o),
      .rd_data_o  (rd_data_o),
      .rd_wren_o  (rd_wren_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Issue one op and follow it to completion; cycle k is N+k for transfer cycle N
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input logic [31:0] exp_data,
                        input string name);
      int          wren_cyc, wren_cnt, ready_cyc, exp_wren_cyc;
      logic [31:0] got_data;
      logic [4:0]  got_addr;
      bit          busy_bad;
      wren_cyc = -1; wren_cnt = 0; ready_cyc = -1; got_data = '0; got_addr = '0; busy_bad = 0;
      exp_wren_cyc = (rd != 5'd0) ? lat : -1;
      @(negedge clk_i);
      n_checks++;
      if (ready_o !== 1'b1) begin
         n_fail++; $display("FAIL %s_ready_at_issue: got %b want 1", name, ready_o);
      end
      op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; valid_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         if (busy_o !== ~ready_o) busy_bad = 1;
         if (rd_wren_o === 1'b1) begin
            wren_cnt++;
            if (wren_cyc < 0) begin
               wren_cyc = k; got_data = rd_data_o; got_addr = rd_addr_o;
            end
         end
         if (ready_o === 1'b1) begin
            ready_cyc = k;
            break;
         end
         @(negedge clk_i);
      end
      n_checks++;
      if (wren_cyc != exp_wren_cyc) begin
         n_fail++; $display("FAIL %s_wren_cycle: got %0d want %0d", name, wren_cyc, exp_wren_cyc);
      end
      n_checks++;
      if (wren_cnt != ((rd != 5'd0) ? 1 : 0)) begin
         n_fail++; $display("FAIL %s_wren_pulses: got %0d want %0d", name, wren_cnt, (rd != 5'd0) ? 1 : 0);
      end
      n_checks++;
      if (ready_cyc != lat + 1) begin
         n_fail++; $display("FAIL %s_ready_cycle: got %0d want %0d", name, ready_cyc, lat + 1);
      end
      n_checks++;
      if (busy_bad) begin
         n_fail++; $display("FAIL %s_busy_vs_ready: got mismatch want busy_o == !ready_o", name);
      end
      if (rd != 5'd0) begin
         n_checks++;
         if (got_data !== exp_data) begin
            n_fail++; $display("FAIL %s_data: got %h want %h", name, got_data, exp_data);
         end
         n_checks++;
         if (got_addr !== rd) begin
            n_fail++; $display("FAIL %s_addr: got %0d want %0d", name, got_addr, rd);
         end
         n_checks++;
         if (rd_data_o !== exp_data) begin
            n_fail++; $display("FAIL %s_data_hold: got %h want %h", name, rd_data_o, exp_data);
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      n_checks++;
      if ({ready_o, busy_o, rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b busy=%b wren=%b addr=%0d data=%h want 1 0 0 0 00000000",
                  ready_o, busy_o, rd_wren_o, rd_addr_o, rd_data_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_mul_basic();
      do_op(MUL, 32'd7, 32'd6, 5'd5, 34, 32'd42, "mul_7x6");
   endtask

   task automatic test_mul_high();
      do_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 34, 32'h0000_0000, "mulh_m1xm1");
      do_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 34, 32'hFFFF_FFFE, "mulhu_max");
      do_op(MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8, 34, 32'hFFFF_FFFF, "mulhsu_m1x2");
   endtask

   task automatic test_divide();
      do_op(DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 34, 32'hFFFF_FFFD, "div_m7_2");
      do_op(REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 34, 32'hFFFF_FFFF, "rem_m7_2");
      do_op(DIVU, 32'd100,       32'd7, 5'd12, 34, 32'd14,        "divu_100_7");
      do_op(REMU, 32'd100,       32'd7, 5'd13, 34, 32'd2,         "remu_100_7");
   endtask

   task automatic test_fast_path();
      do_op(DIVU, 32'd5,         32'd0,         5'd14, 1, 32'hFFFF_FFFF, "divu_by0");
      do_op(REM,  32'd5,         32'd0,         5'd15, 1, 32'd5,         "rem_by0");
      do_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 32'h8000_0000, "div_ovf");
      do_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1, 32'd0,         "rem_ovf");
   endtask

   // First op DIVU 100/7 -> rd3; MUL 5x4 -> rd4 held on the inputs during CALC
   task automatic test_back_to_back();
      int          w1_cyc, w2_cyc, n_wren;
      logic [31:0] d1, d2;
      logic [4:0]  a1, a2;
      logic        rdy35, rdy36, rdy70;
      w1_cyc = -1; w2_cyc = -1; n_wren = 0; d1 = '0; d2 = '0; a1 = '0; a2 = '0;
      rdy35 = 1'b0; rdy36 = 1'b1; rdy70 = 1'b0;
      @(negedge clk_i);
      op_i = DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd3; valid_i = 1'b1;
      @(negedge clk_i);
      op_i = MUL; rs1_data_i = 32'd5; rs2_data_i = 32'd4; rd_addr_i = 5'd4;
      for (int k = 1; k <= 72; k++) begin
         if (k == 35) rdy35 = ready_o;
         if (k == 36) begin
            rdy36   = ready_o;
            valid_i = 1'b0;
         end
         if (k == 70) rdy70 = ready_o;
         if (rd_wren_o === 1'b1) begin
            n_wren++;
            if (w1_cyc < 0) begin
               w1_cyc = k; d1 = rd_data_o; a1 = rd_addr_o;
            end else if (w2_cyc < 0) begin
               w2_cyc = k; d2 = rd_data_o; a2 = rd_addr_o;
            end
         end
         @(negedge clk_i);
      end
      valid_i = 1'b0;
      n_checks++;
      if (w1_cyc != 34 || d1 !== 32'd14 || a1 !== 5'd3) begin
         n_fail++; $display("FAIL b2b_first: got cyc=%0d data=%h addr=%0d want 34 0000000e 3", w1_cyc, d1, a1);
      end
      n_checks++;
      if ({rdy35, rdy36} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_reaccept: got ready35=%b ready36=%b want 1 0", rdy35, rdy36);
      end
      n_checks++;
      if (w2_cyc != 69 || d2 !== 32'd20 || a2 !== 5'd4) begin
         n_fail++; $display("FAIL b2b_second: got cyc=%0d data=%h addr=%0d want 69 00000014 4", w2_cyc, d2, a2);
      end
      n_checks++;
      if (n_wren != 2 || rdy70 !== 1'b1) begin
         n_fail++; $display("FAIL b2b_count: got pulses=%0d ready70=%b want 2 1", n_wren, rdy70);
      end
      do_op(MUL, 32'd3, 32'd3, 5'd0, 34, 32'd9, "mul_rd0");
   endtask

   task automatic test_abort();
      int n_wren;
      n_wren = 0;
      @(negedge clk_i);
      op_i = DIV; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd9; valid_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (rd_wren_o === 1'b1) n_wren++;
         if (k < 10) @(negedge clk_i);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if ({ready_o, busy_o, rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL abort_outputs: got rdy=%b busy=%b wren=%b addr=%0d data=%h want 1 0 0 0 00000000",
                  ready_o, busy_o, rd_wren_o, rd_addr_o, rd_data_o);
      end
      // Reset held together with an offered op must not start it
      op_i = MUL; rs1_data_i = 32'd2; rs2_data_i = 32'd3; rd_addr_i = 5'd1; valid_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_priority: got rdy=%b busy=%b want 1 0", ready_o, busy_o);
      end
      rst_i = 1'b0; valid_i = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (rd_wren_o === 1'b1) n_wren++;
         @(negedge clk_i);
      end
      n_checks++;
      if (n_wren != 0) begin
         n_fail++; $display("FAIL abort_no_write: got %0d pulses want 0", n_wren);
      end
      do_op(MUL, 32'd2, 32'd3, 5'd18, 34, 32'd6, "mul_after_abort");
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_mul_high();
      test_divide();
      test_fast_path();
      test_back_to_back();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
